// File: rtl/sdrd_capture.sv
// sdrd_capture: serial-to-parallel capture of the CLE20 sequencer SDRD stream.
// Bits are sampled on bit_strobe while sdrd_oe is high and assembled into a
// WIDTH-bit word. The word is presented in a holding register with a
// valid/ack handshake. Dropped drive is flagged as frm_err, and a word lost
// to a full holding register is flagged as ovr_err.
// Optional feature: define SDRD_PARITY_EN to append an even-parity bit to
// each frame (WIDTH+1 bits). The result is reported on par_err.
module sdrd_capture #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             bit_strobe,
   input  logic             sdrd,
   input  logic             sdrd_oe,
   input  logic             rd_ack,
   input  logic             clr_err,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             ovr_err,
   output logic             frm_err,
   output logic             par_err
);

`ifdef SDRD_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int            CW       = $clog2(NBITS + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);
   localparam logic [CW-1:0] DATA_CNT = CW'(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_sr_shift;
   logic [WIDTH-1:0] w_word;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_valid;
   logic             r_busy;
   logic             r_ovr_err;
   logic             r_frm_err;

   logic             w_restart;
   logic             w_shift;
   logic             w_abort;
   logic             w_complete;
   logic             w_accept;
   logic             w_drop;
   logic             w_is_data;

   // Shift direction decides where the first sampled bit ends up
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_sr_shift = {r_sr[WIDTH-2:0], sdrd};
      end else begin : g_lsb_first
         assign w_sr_shift = {sdrd, r_sr[WIDTH-1:1]};
      end
   endgenerate

   // Only the first WIDTH bits of a frame are data; a trailing parity bit is not stored
   assign w_is_data = (r_cnt < DATA_CNT);

   // A frame completes on the strobe carrying bit NBITS-1.
   // Without parity, that final bit is data and joins the word on the same edge.
`ifdef SDRD_PARITY_EN
   assign w_word = r_sr;
`else
   assign w_word = w_sr_shift;
`endif

   // Holding register takes the new word if it is empty or being consumed this cycle
   assign w_accept = w_complete & (~r_dout_valid | rd_ack);
   assign w_drop   = w_complete &   r_dout_valid & ~rd_ack;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and frame events; frame_start has priority over bit_strobe
   always_comb begin
      w_state_next = r_state;
      w_restart    = 1'b0;
      w_shift      = 1'b0;
      w_abort      = 1'b0;
      w_complete   = 1'b0;
      case (r_state)
         IDLE: begin
            if (frame_start) begin
               w_restart    = 1'b1;
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (frame_start) begin
               w_restart = 1'b1;
            end else if (bit_strobe) begin
               if (!sdrd_oe) begin
                  w_abort      = 1'b1;
                  w_state_next = IDLE;
               end else begin
                  w_shift = 1'b1;
                  if (r_cnt == LAST_IDX) begin
                     w_complete   = 1'b1;
                     w_state_next = IDLE;
                  end
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Bit counter and shift register; cleared whenever a frame starts or ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_sr  <= '0;
      end else if (w_restart || w_abort || w_complete) begin
         r_cnt <= '0;
         r_sr  <= '0;
      end else if (w_shift) begin
         r_cnt <= r_cnt + 1'b1;
         if (w_is_data) begin
            r_sr <= w_sr_shift;
         end
      end
   end

   // Holding register with valid/ack handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else if (w_accept) begin
         r_dout       <= w_word;
         r_dout_valid <= 1'b1;
      end else if (rd_ack) begin
         r_dout_valid <= 1'b0;
      end
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovr_err <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         r_ovr_err <= w_drop  | (r_ovr_err & ~clr_err);
         r_frm_err <= w_abort | (r_frm_err & ~clr_err);
      end
   end

   // busy is registered from the next state, so it tracks SHIFT without a decode on the output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= (w_state_next == SHIFT);
      end
   end

`ifdef SDRD_PARITY_EN
   logic r_par_acc;
   logic r_par_err;

   // Running XOR over data bits. It is folded with the parity bit on the
   // completing strobe, and the result is loaded together with dout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par_acc <= 1'b0;
         r_par_err <= 1'b0;
      end else begin
         if (w_restart || w_abort || w_complete) begin
            r_par_acc <= 1'b0;
         end else if (w_shift) begin
            r_par_acc <= r_par_acc ^ sdrd;
         end
         if (w_accept) begin
            r_par_err <= r_par_acc ^ sdrd;
         end
      end
   end

   assign par_err = r_par_err;
`else
   assign par_err = 1'b0;
`endif

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign busy       = r_busy;
   assign ovr_err    = r_ovr_err;
   assign frm_err    = r_frm_err;

endmodule

// File: tb/tb_sdrd_capture.sv
// Bench for sdrd_capture. Two instances (MSB-first and LSB-first) share one
// stimulus stream. A frame-level model predicts every cycle's outputs into a
// queue, and a negedge monitor compares both instances against it. Directed
// checks with constant expectations cover the named scenarios.
`timescale 1ns/1ps
module tb_sdrd_capture;
   localparam int W = 8;
`ifdef SDRD_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_start = 1'b0;
   logic bit_strobe = 1'b0;
   logic sdrd = 1'b0;
   logic sdrd_oe = 1'b0;
   logic rd_ack = 1'b0;
   logic clr_err = 1'b0;

   logic [W-1:0] dout_m, dout_l;
   logic valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, frm_m, frm_l, par_m, par_l;

   always #5 clk = ~clk;

   sdrd_capture #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_strobe(bit_strobe),
      .sdrd(sdrd), .sdrd_oe(sdrd_oe), .rd_ack(rd_ack), .clr_err(clr_err),
      .dout(dout_m), .dout_valid(valid_m), .busy(busy_m), .ovr_err(ovr_m),
      .frm_err(frm_m), .par_err(par_m)
   );

   sdrd_capture #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_strobe(bit_strobe),
      .sdrd(sdrd), .sdrd_oe(sdrd_oe), .rd_ack(rd_ack), .clr_err(clr_err),
      .dout(dout_l), .dout_valid(valid_l), .busy(busy_l), .ovr_err(ovr_l),
      .frm_err(frm_l), .par_err(par_l)
   );

   typedef struct packed {
      logic [W-1:0] dm;
      logic [W-1:0] dl;
      logic         v;
      logic         b;
      logic         o;
      logic         f;
      logic         p;
   } snap_t;

   snap_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   // Frame-level reference state: the bits received so far, plus the visible outputs
   bit           m_in_frame, m_valid, m_ovr, m_frm, m_par;
   bit           m_bits[$];
   logic [W-1:0] m_dm, m_dl;

   task automatic model_reset();
      m_in_frame = 0; m_valid = 0; m_ovr = 0; m_frm = 0; m_par = 0;
      m_dm = '0; m_dl = '0;
      m_bits.delete();
   endtask

   task automatic model_step();
      bit ovr_ev, frm_ev, old_valid;
      int ones;
      snap_t s;
      if (!rst_n) begin
         model_reset();
      end else begin
         ovr_ev = 0; frm_ev = 0; old_valid = m_valid;
         if (rd_ack) m_valid = 0;
         if (frame_start) begin
            m_in_frame = 1;
            m_bits.delete();
         end else if (m_in_frame && bit_strobe) begin
            if (!sdrd_oe) begin
               frm_ev = 1;
               m_in_frame = 0;
               m_bits.delete();
            end else begin
               m_bits.push_back(sdrd);
               if (m_bits.size() == NB) begin
                  m_in_frame = 0;
                  if (!old_valid || rd_ack) begin
                     ones = 0;
                     for (int i = 0; i < W; i++) begin
                        m_dm[W-1-i] = m_bits[i];
                        m_dl[i]     = m_bits[i];
                     end
                     for (int i = 0; i < NB; i++) ones += int'(m_bits[i]);
`ifdef SDRD_PARITY_EN
                     m_par = ones[0];
`else
                     m_par = 0;
`endif
                     m_valid = 1;
                     $display("txn t=%0t load msb=%h lsb=%h par=%b", $time, m_dm, m_dl, m_par);
                  end else begin
                     ovr_ev = 1;
                     $display("txn t=%0t overrun, held word %h kept", $time, m_dm);
                  end
                  m_bits.delete();
               end
            end
         end
         m_ovr = ovr_ev | (m_ovr & !clr_err);
         m_frm = frm_ev | (m_frm & !clr_err);
      end
      s.dm = m_dm; s.dl = m_dl; s.v = m_valid; s.b = m_in_frame;
      s.o = m_ovr; s.f = m_frm; s.p = m_par;
      exp_q.push_back(s);
   endtask

   // Model advances on the same edge as the DUT, seeing the same inputs
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: pop one prediction per cycle and compare both instances
   initial begin
      snap_t e;
      logic [12:0] am, al, em, el;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rst_n) begin
               am = {dout_m, valid_m, busy_m, ovr_m, frm_m, par_m};
               al = {dout_l, valid_l, busy_l, ovr_l, frm_l, par_l};
               em = {e.dm, e.v, e.b, e.o, e.f, e.p};
               el = {e.dl, e.v, e.b, e.o, e.f, e.p};
               n_checks++;
               if (am !== em) begin
                  n_errors++;
                  $display("FAIL sb_msb t=%0t got dout/v/b/o/f/p=%h expected %h", $time, am, em);
               end
               n_checks++;
               if (al !== el) begin
                  n_errors++;
                  $display("FAIL sb_lsb t=%0t got dout/v/b/o/f/p=%h expected %h", $time, al, el);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s t=%0t got %h expected %h", name, $time, act, expv);
      end
   endtask

   task automatic cyc(input bit fs, input bit bs, input bit sd, input bit oe,
                      input bit ack, input bit clr);
      frame_start = fs; bit_strobe = bs; sdrd = sd; sdrd_oe = oe;
      rd_ack = ack; clr_err = clr;
      @(posedge clk);
      #1;
      frame_start = 0; bit_strobe = 0; rd_ack = 0; clr_err = 0;
   endtask

   // frame_start, then data bits first-to-last as data[W-1] .. data[0], then the parity bit if enabled
   task automatic send_frame(input logic [W-1:0] data, input bit pb, input bit ack_last);
      bit b;
      cyc(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < NB; i++) begin
         b = (i < W) ? data[W-1-i] : pb;
         cyc(0, 1, b, 1, (i == NB-1) ? ack_last : 1'b0, 0);
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dout", {dout_m, dout_l}, 16'h0000);
      chk("reset_flags", {6'd0, valid_m, busy_m, ovr_m, frm_m, par_m,
                          valid_l, busy_l, ovr_l, frm_l, par_l}, 16'h0000);
      rst_n = 1;
      cyc(0, 0, 0, 0, 0, 0);

      // 0xA5 MSB first; the pattern is a palindrome so LSB first also gives 0xA5
      send_frame(8'hA5, 1'b0, 1'b0);
      chk("a5_dout", {dout_m, dout_l}, 16'hA5A5);
      chk("a5_valid", {14'd0, valid_m, valid_l}, 16'h0003);
      chk("a5_par", {14'd0, par_m, par_l}, 16'h0000);
      cyc(0, 0, 0, 1, 1, 0);
      chk("a5_ack_valid", {14'd0, valid_m, valid_l}, 16'h0000);

      // First sampled bit position
      send_frame(8'h80, 1'b0, 1'b0);
      chk("first_bit_pos", {dout_m, dout_l}, 16'h8001);
      cyc(0, 0, 0, 1, 1, 0);

      // Overrun: 0x3C held, 0xFF dropped
      send_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0);
      chk("ovr_dout", {8'h00, dout_m}, 16'h003C);
      chk("ovr_flags", {13'd0, valid_m, ovr_m, busy_m}, 16'h0006);
      cyc(0, 0, 0, 1, 0, 1);
      chk("ovr_clr", {14'd0, valid_m, ovr_m}, 16'h0002);

      // Completing with rd_ack in the same cycle replaces the held word
      send_frame(8'hFF, 1'b0, 1'b1);
      chk("ack_same_dout", {8'h00, dout_m}, 16'h00FF);
      chk("ack_same_flags", {14'd0, valid_m, ovr_m}, 16'h0002);
      cyc(0, 0, 0, 1, 1, 0);

      // Framing error after 3 bits
      cyc(1, 0, 0, 1, 0, 0);
      chk("busy_rise", {15'd0, busy_m}, 16'h0001);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1'(i), 1, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
      chk("frm_flags", {14'd0, frm_m, busy_m}, 16'h0002);
      chk("frm_dout", {8'h00, dout_m}, 16'h00FF);
      cyc(0, 0, 0, 1, 0, 1);

      // Asynchronous reset mid-frame, then a clean frame
      cyc(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0, 0);
      rst_n = 0;
      #1;
      chk("async_rst", {dout_m, 3'd0, valid_m, busy_m, ovr_m, frm_m, par_m}, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      send_frame(8'h81, 1'b0, 1'b0);
      chk("post_rst_dout", {dout_m, dout_l}, 16'h8181);
      chk("post_rst_valid", {15'd0, valid_m}, 16'h0001);
      cyc(0, 0, 0, 1, 1, 0);

`ifdef SDRD_PARITY_EN
      send_frame(8'hA5, 1'b1, 1'b0);
      chk("par_bad", {14'd0, par_m, par_l}, 16'h0003);
      cyc(0, 0, 0, 1, 1, 0);
      send_frame(8'hA5, 1'b0, 1'b0);
      chk("par_good", {14'd0, par_m, par_l}, 16'h0000);
      cyc(0, 0, 0, 1, 1, 0);
`endif

      // Randomized traffic, checked by the scoreboard
      for (int k = 0; k < 4000; k++) begin
         cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) != 0),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 24) == 0));
      end
      repeat (3) cyc(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/sdrd_capture.md
# sdrd_capture

Serial-to-parallel capture stage directly downstream of the CLE20 serial-read sequencer. Samples the sequencer's SDRD bit stream on a per-bit strobe while the sequencer actually drives the line, assembles a WIDTH-bit word, and presents it in a holding register with a valid/acknowledge handshake to the bus-read side. Detects dropped-drive (framing) errors and overrun.

## Interface
- WIDTH, 8: data bits per frame, 2..16
- MSB_FIRST, 1: 1 means the first sampled bit lands in dout[WIDTH-1]; 0 means it lands in dout[0]

- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; begins a new frame and discards any partial one
- bit_strobe  in  1  one-cycle pulse; sample point for the current serial bit
- sdrd  in  1  serial data from the sequencer
- sdrd_oe  in  1  high while the sequencer drives sdrd (its tristate-enable term)
- rd_ack  in  1  one-cycle pulse from the bus side; consumes the held word
- clr_err  in  1  clears the sticky error flags
- dout  out  WIDTH  holding register
- dout_valid  out  1  holding register contains an unconsumed word
- busy  out  1  frame in progress (state SHIFT)
- ovr_err  out  1  sticky; a completed word was dropped
- frm_err  out  1  sticky; a bit_strobe arrived while sdrd_oe was low
- par_err  out  1  parity result for the held word (see Configuration)

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: frame_start -> SHIFT, clear bit counter and shift register. bit_strobe is ignored.
- SHIFT with bit_strobe and sdrd_oe=1: shift in sdrd in MSB_FIRST order and increment the counter. The counter width is clog2(NBITS+1), where NBITS = WIDTH, or WIDTH+1 with parity.
- SHIFT with bit_strobe and sdrd_oe=0: set frm_err, discard the partial word, go to IDLE.
- Frame completes when the counter reaches NBITS on a valid strobe:
  - If dout_valid=0, or rd_ack is asserted in the same cycle: load dout, set dout_valid=1.
  - Otherwise: keep dout unchanged, drop the new word, set ovr_err.
  - In both cases, go to IDLE.
- frame_start in SHIFT: restart. Counter and shift register clear, stay in SHIFT, no error.
- frame_start and bit_strobe in the same cycle: frame_start wins and the strobe is discarded.
- rd_ack: clears dout_valid. rd_ack with dout_valid=0 has no effect.
- clr_err clears ovr_err and frm_err. If a new error event occurs in the same cycle, the event wins and the flag stays set.

## Timing
- Reset values: dout=0, dout_valid=0, busy=0, ovr_err=0, frm_err=0, par_err=0, state IDLE, counter=0.
- Reset mid-frame abandons the frame immediately and asynchronously. No partial word appears.
- Latency: the edge that samples the final bit also loads dout and sets dout_valid. Both are visible in the following cycle.
- busy rises on the edge after frame_start and falls on the completing or aborting edge.
- Back-to-back strobes on consecutive cycles are supported.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SDRD_PARITY_EN defined:
  - Each frame carries WIDTH+1 bits, and the final bit is a parity bit that is not stored in dout.
  - Even parity is checked over the data bits plus the parity bit.
  - par_err is loaded with dout: 1 on mismatch, 0 otherwise.
  - A dropped (overrun) word does not change par_err.
- SDRD_PARITY_EN undefined: the frame is WIDTH bits and par_err is held at 0.

## Test plan
- WIDTH=8, MSB_FIRST=1, frame_start then 8 strobes carrying 1,0,1,0,0,1,0,1 -> dout=0xA5 and dout_valid=1 one cycle after the 8th strobe. rd_ack then gives dout_valid=0.
- Same bits with MSB_FIRST=0 -> dout=0xA5 when the bit sequence is reversed (1,0,1,0,0,1,0,1 again) and dout=0xA5 bit-mirrored otherwise. Check that the first sampled bit lands at dout[0].
- Complete 0x3C and do not ack, then complete 0xFF -> dout stays 0x3C and ovr_err=1. clr_err clears ovr_err while dout_valid stays 1.
- Complete the second frame with rd_ack on the completing cycle -> dout=0xFF, dout_valid=1, ovr_err=0.
- After 3 strobes, a strobe with sdrd_oe=0 -> frm_err=1, busy=0, dout unchanged. Separately, a rst_n pulse after 5 bits gives all outputs 0, and a following full frame of 0x81 captures cleanly.
- With SDRD_PARITY_EN: data 0xA5 plus parity bit 0 -> par_err=0. Data 0xA5 plus parity bit 1 -> par_err=1.
